// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter
//   Shares one pipelined single-precision FP add/sub datapath between NUM_REQ
//   requesters. A round-robin arbiter picks one requester per cycle. The chosen
//   operands are registered and issued to the datapath. The requester index is
//   pushed into an in-order tag FIFO. Because results come back in issue order,
//   the head of that FIFO tells us which requester each result belongs to.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   req_valid/ready    per-requester handshake; req_ready is one-hot or zero
//   req_a/b            packed operands, requester i at [32i+31:32i]
//   req_op             per-requester op select (0 add, 1 subtract)
//   issue_*            registered op to the datapath (always accepted)
//   res_valid/data     in-order result from the datapath
//   rsp_valid/data     one-hot result strobe and shared result data
//   outstanding        number of ops accepted but not yet returned
//   err_orphan         sticky flag: a result arrived with nothing in flight
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*32-1:0]        req_a,
    input  logic [NUM_REQ*32-1:0]        req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic                         issue_valid,
    output logic [31:0]                  issue_a,
    output logic [31:0]                  issue_b,
    output logic                         issue_op,
    input  logic                         res_valid,
    input  logic [31:0]                  res_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [31:0]                  rsp_data,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_orphan
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = $clog2(MAX_OUT+1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] tag_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [31:0]      a_arr [NUM_REQ];
    logic [31:0]      b_arr [NUM_REQ];
    logic             pop;
    logic             slot_free;
    logic             grant_found;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] cand;

    // outstanding doubles as the tag FIFO occupancy, so it is also the empty test.
    assign pop = res_valid && (outstanding != '0);

    // A result leaving in this cycle frees its slot for a same-cycle accept.
    assign slot_free = (outstanding < CNT_W'(MAX_OUT)) || res_valid;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*32 +: 32];
            b_arr[i] = req_b[i*32 +: 32];
        end
    end

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_ready   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand] && slot_free && !rst) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: the tag storage has no reset; the pointers and count define which entries are live, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (grant_found) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rr_ptr      <= TAG_W'(NUM_REQ - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            issue_valid <= 1'b0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_op    <= 1'b0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            err_orphan  <= 1'b0;
        end else begin
            issue_valid <= grant_found;
            if (grant_found) begin
                rr_ptr   <= grant_idx;
                wr_ptr   <= wr_ptr + PTR_W'(1);
                issue_a  <= a_arr[grant_idx];
                issue_b  <= b_arr[grant_idx];
                issue_op <= req_op[grant_idx];
            end

            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[tag_mem[rd_ptr]] <= 1'b1;
                rsp_data                   <= res_data;
                rd_ptr                     <= rd_ptr + PTR_W'(1);
            end

            if (res_valid && !pop) begin
                err_orphan <= 1'b1;
            end

            case ({grant_found, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
